kbd_buffer_ctrl: RTL and testbench

Controller for the keyboard scancode ring buffer. It is the single clock-domain owner of the 32-entry key queue and its head/tail pointers. It takes byte strobes from the PS/2 receiver and decodes the E0/F0 prefixes into make events carrying modifier state. It serialises receiver pushes against CPU memory-mapped accesses: head write, tail/status read and data-window read. It sits between the PS/2 receiver and the CPU data bus, in place of ad-hoc multi-edge pointer logic.

---
 rtl/kbd_pkg.sv | 41 ++++
 rtl/kbd_buffer_ctrl_if.sv | 13 +
 rtl/kbd_prefix_fsm.sv | 79 +++++++
 rtl/kbd_buffer_ctrl.sv | 142 ++++++++++++++
 tb/tb_kbd_buffer_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/kbd_pkg.sv
// Shared constants and types for the keyboard scancode ring buffer controller.
package kbd_pkg;

  localparam int          DEF_DEPTH_LOG2 = 5;
  localparam logic [31:0] DEF_HEAD_ADDR  = 32'h003ffff0;
  localparam logic [31:0] DEF_TAIL_ADDR  = 32'h003fffe0;
  localparam logic [31:0] DEF_STAT_ADDR  = 32'h003fffd0;
  localparam logic [31:0] DEF_DATA_BASE  = 32'h00300000;
  localparam logic [31:0] DEF_DATA_MASK  = 32'hfff00000;

  localparam logic [7:0] PFX_E0     = 8'hE0;
  localparam logic [7:0] PFX_F0     = 8'hF0;
  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CAPS   = 8'h58;

  localparam int ENT_CODE_LSB  = 0;
  localparam int ENT_EXT_BIT   = 8;
  localparam int ENT_SHIFT_BIT = 9;
  localparam int ENT_CAPS_BIT  = 10;
  localparam int ENT_W         = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXT    = 2'd1,
    BRK    = 2'd2,
    EXTBRK = 2'd3
  } pfx_state_e;

  function automatic logic [ENT_W-1:0] pack_entry(input logic caps, input logic shift,
                                                  input logic ext, input logic [7:0] code);
    logic [ENT_W-1:0] e;
    e = '0;
    e[ENT_CAPS_BIT]              = caps;
    e[ENT_SHIFT_BIT]             = shift;
    e[ENT_EXT_BIT]               = ext;
    e[ENT_CODE_LSB +: 8]         = code;
    return e;
  endfunction

endpackage

// File: rtl/kbd_buffer_ctrl_if.sv
// CPU memory-mapped access bus between the CPU (master) and the key buffer (slave).
interface kbd_buffer_ctrl_if;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (output bus_addr, output bus_we, output bus_re, output bus_wdata,
                  input bus_rdata);
  modport slave  (input bus_addr, input bus_we, input bus_re, input bus_wdata,
                  output bus_rdata);
endinterface

// File: rtl/kbd_prefix_fsm.sv
// Decodes E0/F0 scancode prefixes into make/break events with the extended flag.
// state  | meaning
// IDLE   | no prefix pending
// EXT    | E0 seen, extended key follows
// BRK    | F0 seen, break of a normal key follows
// EXTBRK | E0 F0 seen, break of an extended key follows
module kbd_prefix_fsm
  import kbd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_vld,
  input  logic [7:0] rx_byte,
  output logic       evt_vld,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk
);

  pfx_state_e state_q;
  logic       evt_vld_q;
  logic [7:0] evt_code_q;
  logic       evt_ext_q;
  logic       evt_brk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      evt_vld_q  <= 1'b0;
      evt_code_q <= 8'h00;
      evt_ext_q  <= 1'b0;
      evt_brk_q  <= 1'b0;
    end else begin
      evt_vld_q <= 1'b0;
      if (byte_vld) begin
        evt_code_q <= rx_byte;
        unique case (state_q)
          IDLE: begin
            if (rx_byte == PFX_E0)      state_q <= EXT;
            else if (rx_byte == PFX_F0) state_q <= BRK;
            else begin
              evt_vld_q <= 1'b1;
              evt_ext_q <= 1'b0;
              evt_brk_q <= 1'b0;
            end
          end
          EXT: begin
            if (rx_byte == PFX_F0)      state_q <= EXTBRK;
            else if (rx_byte != PFX_E0) begin
              evt_vld_q <= 1'b1;
              evt_ext_q <= 1'b1;
              evt_brk_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
          BRK: begin
            evt_vld_q <= 1'b1;
            evt_ext_q <= 1'b0;
            evt_brk_q <= 1'b1;
            state_q   <= IDLE;
          end
          EXTBRK: begin
            evt_vld_q <= 1'b1;
            evt_ext_q <= 1'b1;
            evt_brk_q <= 1'b1;
            state_q   <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign evt_vld  = evt_vld_q;
  assign evt_code = evt_code_q;
  assign evt_ext  = evt_ext_q;
  assign evt_brk  = evt_brk_q;

endmodule

// File: rtl/kbd_buffer_ctrl.sv
// Keyboard scancode ring buffer: receiver sync, modifier tracking, queue storage,
// head/tail pointers and CPU register decode, all in the CLK100MHZ domain.
module kbd_buffer_ctrl
  import kbd_pkg::*;
#(
  parameter int          DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter logic [31:0] HEAD_ADDR  = DEF_HEAD_ADDR,
  parameter logic [31:0] TAIL_ADDR  = DEF_TAIL_ADDR,
  parameter logic [31:0] STAT_ADDR  = DEF_STAT_ADDR,
  parameter logic [31:0] DATA_BASE  = DEF_DATA_BASE,
  parameter logic [31:0] DATA_MASK  = DEF_DATA_MASK
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  input  logic               rx_ready,
  input  logic [7:0]         rx_code,
  kbd_buffer_ctrl_if.slave   bus,
  output logic               kbd_empty,
  output logic               kbd_full,
  output logic               kbd_irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int DW    = DEPTH_LOG2;

  logic             sync1_q, sync2_q, prev_q;
  logic             rx_edge;
  logic             evt_vld, evt_ext, evt_brk;
  logic [7:0]       evt_code;

  logic [DW-1:0]    head_q, head_d, tail_q, tail_d, tail_inc, data_idx;
  logic             shift_q, shift_d, caps_q, caps_d, ovf_q, ovf_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [ENT_W-1:0] slot_q [DEPTH];
  logic [ENT_W-1:0] entry;
  logic             slot_we, push, full, empty, is_shift_key, in_data_win;
  logic             unused_bits;

  assign rx_edge = sync2_q & ~prev_q;

  kbd_prefix_fsm u_prefix (
    .clk      (CLK100MHZ),
    .rst      (reset),
    .byte_vld (rx_edge),
    .rx_byte  (rx_code),
    .evt_vld  (evt_vld),
    .evt_code (evt_code),
    .evt_ext  (evt_ext),
    .evt_brk  (evt_brk)
  );

  assign tail_inc     = tail_q + DW'(1);
  assign full         = (tail_inc == head_q);
  assign empty        = (head_q == tail_q);
  assign data_idx     = bus.bus_addr[DW+1:2] + DW'(1);
  assign is_shift_key = (evt_code == KEY_LSHIFT) || (evt_code == KEY_RSHIFT);
  // Register addresses sit inside the data window's address range; they decode first.
  assign in_data_win  = ((bus.bus_addr & DATA_MASK) == DATA_BASE) && (bus.bus_addr[1:0] == 2'b00);
  assign unused_bits  = ^bus.bus_wdata;

  always_comb begin
    shift_d = shift_q;
    caps_d  = caps_q;
    if (evt_vld) begin
      if (!evt_brk) begin
        if (!evt_ext && is_shift_key) shift_d = 1'b1;
        if (evt_code == KEY_CAPS)     caps_d  = ~caps_q;
      end else if (!evt_ext && is_shift_key) begin
        shift_d = 1'b0;
      end
    end
    push  = evt_vld & ~evt_brk;
    entry = pack_entry(caps_d, shift_d, evt_ext, evt_code);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    ovf_d   = ovf_q;
    slot_we = 1'b0;
    if (bus.bus_we && bus.bus_addr == STAT_ADDR && bus.bus_wdata[2]) ovf_d = 1'b0;
    // Full test uses the pre-write head; a coincident overflow set beats the clear.
    if (push) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        slot_we = 1'b1;
        tail_d  = tail_inc;
      end
    end
    if (bus.bus_we && bus.bus_addr == HEAD_ADDR) head_d = bus.bus_wdata[DW-1:0];
  end

  always_comb begin
    rdata_d = rdata_q;
    if (bus.bus_re) begin
      if (bus.bus_addr == HEAD_ADDR)      rdata_d = 32'(head_q);
      else if (bus.bus_addr == TAIL_ADDR) rdata_d = 32'(tail_q);
      else if (bus.bus_addr == STAT_ADDR) rdata_d = {27'b0, caps_q, shift_q, ovf_q, full, empty};
      else if (in_data_win)               rdata_d = 32'(slot_q[data_idx]);
      else                                rdata_d = 32'h0;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      shift_q <= 1'b0;
      caps_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      sync1_q <= rx_ready;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      head_q  <= head_d;
      tail_q  <= tail_d;
      shift_q <= shift_d;
      caps_q  <= caps_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else if (slot_we) begin
      slot_q[tail_inc] <= entry;
    end
  end

  assign bus.bus_rdata = rdata_q;
  assign kbd_empty     = empty;
  assign kbd_full      = full;
  assign kbd_irq       = ~empty;

endmodule

// File: tb/tb_kbd_buffer_ctrl.sv
// Directed self-checking bench for kbd_buffer_ctrl.
module tb_kbd_buffer_ctrl;

  localparam logic [31:0] HEAD = 32'h003ffff0;
  localparam logic [31:0] TAIL = 32'h003fffe0;
  localparam logic [31:0] STAT = 32'h003fffd0;
  localparam logic [31:0] DATA = 32'h00300000;

  logic       CLK100MHZ = 1'b0;
  logic       reset     = 1'b1;
  logic       rx_ready  = 1'b0;
  logic [7:0] rx_code   = 8'h00;
  logic       kbd_empty, kbd_full, kbd_irq;
  int         total = 0;
  int         bad   = 0;

  kbd_buffer_ctrl_if bus_if ();

  kbd_buffer_ctrl dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .rx_ready  (rx_ready),
    .rx_code   (rx_code),
    .bus       (bus_if),
    .kbd_empty (kbd_empty),
    .kbd_full  (kbd_full),
    .kbd_irq   (kbd_irq)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic do_reset();
    @(negedge CLK100MHZ);
    reset = 1'b1;
    repeat (2) @(negedge CLK100MHZ);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] c);
    @(negedge CLK100MHZ);
    rx_code  = c;
    rx_ready = 1'b1;
    repeat (4) @(negedge CLK100MHZ);
    rx_ready = 1'b0;
    repeat (4) @(negedge CLK100MHZ);
  endtask

  // Bus write lands on the same clock edge as the push caused by this byte.
  task automatic send_byte_with_write(input logic [7:0] c, input logic [31:0] a,
                                      input logic [31:0] d);
    @(negedge CLK100MHZ);
    rx_code  = c;
    rx_ready = 1'b1;
    repeat (3) @(negedge CLK100MHZ);
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = d;
    bus_if.bus_we    = 1'b1;
    @(negedge CLK100MHZ);
    bus_if.bus_we = 1'b0;
    rx_ready      = 1'b0;
    repeat (4) @(negedge CLK100MHZ);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK100MHZ);
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = d;
    bus_if.bus_we    = 1'b1;
    @(negedge CLK100MHZ);
    bus_if.bus_we = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge CLK100MHZ);
    bus_if.bus_addr = a;
    bus_if.bus_re   = 1'b1;
    @(negedge CLK100MHZ);
    bus_if.bus_re = 1'b0;
    d = bus_if.bus_rdata;
  endtask

  task automatic bus_wr_rd(input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    @(negedge CLK100MHZ);
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = wd;
    bus_if.bus_we    = 1'b1;
    bus_if.bus_re    = 1'b1;
    @(negedge CLK100MHZ);
    bus_if.bus_we = 1'b0;
    bus_if.bus_re = 1'b0;
    rd = bus_if.bus_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    total++; if (kbd_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", kbd_empty); end
    total++; if (kbd_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", kbd_full); end
    total++; if (kbd_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", kbd_irq); end
    total++; if (bus_if.bus_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus_if.bus_rdata); end
    bus_rd(TAIL, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_tail got=%h exp=0", d); end
    bus_rd(STAT, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL reset_stat got=%h exp=1", d); end
  endtask

  task automatic test_make_break();
    logic [31:0] d;
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    bus_rd(TAIL, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL mb_tail got=%h exp=1", d); end
    bus_rd(DATA, d);
    total++; if (d !== 32'h1C) begin bad++; $display("FAIL mb_data got=%h exp=1c", d); end
    total++; if (kbd_irq !== 1'b1) begin bad++; $display("FAIL mb_irq got=%b exp=1", kbd_irq); end
    bus_wr(HEAD, 32'h1);
    bus_rd(STAT, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL mb_stat got=%h exp=1", d); end
    total++; if (kbd_irq !== 1'b0) begin bad++; $display("FAIL mb_irq_clr got=%b exp=0", kbd_irq); end
  endtask

  task automatic test_shift_ext();
    logic [31:0] d;
    send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12);
    bus_rd(DATA + 32'd4, d);
    total++; if (d !== 32'h212) begin bad++; $display("FAIL shift_make got=%h exp=212", d); end
    bus_rd(DATA + 32'd8, d);
    total++; if (d !== 32'h21C) begin bad++; $display("FAIL shift_key got=%h exp=21c", d); end
    bus_rd(STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL shift_stat got=%h exp=0", d); end
    send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    bus_rd(TAIL, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL ext_tail got=%h exp=4", d); end
    bus_rd(DATA + 32'd12, d);
    total++; if (d !== 32'h175) begin bad++; $display("FAIL ext_entry got=%h exp=175", d); end
  endtask

  task automatic test_caps();
    logic [31:0] d;
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    bus_rd(DATA + 32'd16, d);
    total++; if (d !== 32'h458) begin bad++; $display("FAIL caps_on_entry got=%h exp=458", d); end
    bus_rd(STAT, d);
    total++; if (d !== 32'h10) begin bad++; $display("FAIL caps_on_stat got=%h exp=10", d); end
    send_byte(8'h58);
    bus_rd(DATA + 32'd20, d);
    total++; if (d !== 32'h058) begin bad++; $display("FAIL caps_off_entry got=%h exp=58", d); end
    bus_rd(STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL caps_off_stat got=%h exp=0", d); end
    bus_rd(TAIL, d);
    total++; if (d !== 32'h6) begin bad++; $display("FAIL caps_tail got=%h exp=6", d); end
  endtask

  task automatic test_fill_wrap();
    logic [31:0] d;
    do_reset();
    for (int k = 0; k < 32; k++) send_byte(8'h60 + 8'(k));
    bus_rd(TAIL, d);
    total++; if (d !== 32'd31) begin bad++; $display("FAIL fill_tail got=%h exp=1f", d); end
    total++; if (kbd_full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", kbd_full); end
    bus_rd(STAT, d);
    total++; if (d !== 32'h6) begin bad++; $display("FAIL fill_stat got=%h exp=6", d); end
    bus_rd(DATA, d);
    total++; if (d !== 32'h60) begin bad++; $display("FAIL fill_first got=%h exp=60", d); end
    bus_rd(DATA + 32'd120, d);
    total++; if (d !== 32'h7E) begin bad++; $display("FAIL fill_last got=%h exp=7e", d); end
    bus_rd(DATA + 32'd124, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL fill_unused got=%h exp=0", d); end
    bus_wr(STAT, 32'h4);
    bus_rd(STAT, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL ovf_clear got=%h exp=2", d); end
    bus_wr(HEAD, 32'd31);
    bus_rd(STAT, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL head31_stat got=%h exp=1", d); end
    send_byte(8'h33);
    bus_rd(TAIL, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL wrap_tail got=%h exp=0", d); end
    bus_rd(DATA + 32'd124, d);
    total++; if (d !== 32'h33) begin bad++; $display("FAIL wrap_slot0 got=%h exp=33", d); end
    bus_wr(HEAD, 32'hABCD0021);
    bus_rd(HEAD, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL head_mask got=%h exp=1", d); end
    total++; if (kbd_full !== 1'b1) begin bad++; $display("FAIL head_mask_full got=%b exp=1", kbd_full); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    send_byte_with_write(8'h44, HEAD, 32'h5);
    bus_rd(TAIL, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL b2b_tail got=%h exp=0", d); end
    bus_rd(HEAD, d);
    total++; if (d !== 32'h5) begin bad++; $display("FAIL b2b_head got=%h exp=5", d); end
    bus_rd(STAT, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL b2b_stat got=%h exp=4", d); end
    bus_wr_rd(HEAD, 32'h7, d);
    total++; if (d !== 32'h5) begin bad++; $display("FAIL wr_rd_old got=%h exp=5", d); end
    bus_rd(HEAD, d);
    total++; if (d !== 32'h7) begin bad++; $display("FAIL wr_rd_new got=%h exp=7", d); end
    bus_wr(HEAD, 32'h1);
    bus_wr(STAT, 32'h4);
    bus_rd(STAT, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL pre_setclr_stat got=%h exp=2", d); end
    send_byte_with_write(8'h45, STAT, 32'h4);
    bus_rd(STAT, d);
    total++; if (d !== 32'h6) begin bad++; $display("FAIL set_wins got=%h exp=6", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    send_byte(8'hE0);
    do_reset();
    bus_rd(TAIL, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_tail got=%h exp=0", d); end
    bus_rd(STAT, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL mid_stat got=%h exp=1", d); end
    send_byte(8'h1C);
    bus_rd(DATA, d);
    total++; if (d !== 32'h1C) begin bad++; $display("FAIL mid_entry got=%h exp=1c", d); end
  endtask

  initial begin
    bus_if.bus_addr  = 32'h0;
    bus_if.bus_wdata = 32'h0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_re    = 1'b0;
    test_reset();
    test_make_break();
    test_shift_ext();
    test_caps();
    test_fill_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
